// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin rq/ack arbiter forwarding one client transfer at a time to a shared server
// Optional macro ARB_TIMEOUT_EN bounds the RELEASE wait and raises a sticky err_timeout.
module bus_arbiter #(
   parameter int NUM_CLIENTS     = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int RELEASE_TIMEOUT = 16,
   localparam int ID_W           = $clog2(NUM_CLIENTS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            rq,
   output logic [NUM_CLIENTS-1:0]            ack,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
   input  logic [NUM_CLIENTS-1:0]            wr_ni,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
   output logic [DATA_WIDTH-1:0]             dataR,
   output logic                              srv_rq,
   input  logic                              srv_ack,
   output logic [ADDR_WIDTH-1:0]             srv_address,
   output logic                              srv_wr_ni,
   output logic [DATA_WIDTH-1:0]             srv_dataW,
   input  logic [DATA_WIDTH-1:0]             srv_dataR,
   output logic [ID_W-1:0]                   grant_id,
   output logic                              busy,
   output logic                              err_timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SERVE   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   if (NUM_CLIENTS < 2 || RELEASE_TIMEOUT < 1) begin : g_param_check
      $error("bus_arbiter: NUM_CLIENTS must be >= 2 and RELEASE_TIMEOUT >= 1");
   end

   logic [1:0]      state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] next_ptr;
   logic            win_found;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] cand;

   // First requester at or after ptr, wrapping around the client ring.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_CLIENTS);
         if (!win_found && rq[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign next_ptr = (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(RELEASE_TIMEOUT + 1);
   logic [CNT_W-1:0] rel_cnt;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         ack         <= '0;
         dataR       <= '0;
         srv_rq      <= 1'b0;
         srv_address <= '0;
         srv_wr_ni   <= 1'b0;
         srv_dataW   <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         rel_cnt     <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  grant_id    <= win_id;
                  srv_address <= address[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                  srv_wr_ni   <= wr_ni[win_id];
                  srv_dataW   <= dataW[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                  srv_rq      <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (srv_ack) begin
                  srv_rq        <= 1'b0;
                  ack[grant_id] <= 1'b1;
                  if (srv_wr_ni) dataR <= srv_dataR;
                  state         <= ST_RELEASE;
`ifdef ARB_TIMEOUT_EN
                  rel_cnt       <= '0;
`endif
               end
            end
            ST_RELEASE: begin
               if (!rq[grant_id]) begin
                  ptr   <= next_ptr;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (rel_cnt == CNT_W'(RELEASE_TIMEOUT - 1)) begin
                  ptr         <= next_ptr;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  rel_cnt <= rel_cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    rq, ack, wr_ni;
   logic [N*AW-1:0] address;
   logic [N*DW-1:0] dataW;
   logic [DW-1:0]   dataR, srv_dataW, srv_dataR;
   logic            srv_rq, srv_ack, srv_wr_ni, busy, err_timeout;
   logic [AW-1:0]   srv_address;
   logic [1:0]      grant_id;

   bus_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RELEASE_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .rq(rq), .ack(ack), .address(address), .wr_ni(wr_ni),
      .dataW(dataW), .dataR(dataR), .srv_rq(srv_rq), .srv_ack(srv_ack),
      .srv_address(srv_address), .srv_wr_ni(srv_wr_ni), .srv_dataW(srv_dataW),
      .srv_dataR(srv_dataR), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int g_id[$];
   int g_addr[$];
   int g_wr[$];
   int g_dw[$];
   int ack_cnt[N];
   int ack_epoch = 0;
   int seen_epoch = 0;
   int srv_delay = 3;
   int spur_seq = 0;
   int spur_done = 0;
   logic [DW-1:0] srv_rd_data;
   logic [N-1:0]  hold;
   logic [N-1:0]  ack_seen;
   bit            reraise_en;
   int            rr_cnt[N];

   // Transaction-level model: open/acked flags, grant by ring distance from ptr
   bit            m_valid = 1'b0;
   bit            m_open, m_acked, m_err;
   int            m_ptr, m_gid, m_ack, m_rel;
   logic [AW-1:0] m_addr;
   logic          m_wr;
   logic [DW-1:0] m_dw, m_dr;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int gq(input int k);
      return (k < g_id.size()) ? g_id[k] : -1;
   endfunction
   function automatic int aq(input int k);
      return (k < g_addr.size()) ? g_addr[k] : -1;
   endfunction
   function automatic int wq(input int k);
      return (k < g_wr.size()) ? g_wr[k] : -1;
   endfunction
   function automatic int dq(input int k);
      return (k < g_dw.size()) ? g_dw[k] : -1;
   endfunction
   function automatic bit rr_pending();
      for (int i = 0; i < N; i++) if (rr_cnt[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Model step on each edge, comparison on the following falling edge.
   initial begin : cmp
      int   best, bestd, d;
      logic prev_srv_rq;
      logic [N-1:0] exp_ack;
      prev_srv_rq = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_valid = 1'b1; m_open = 1'b0; m_acked = 1'b0; m_err = 1'b0;
            m_ptr = 0; m_gid = 0; m_ack = -1; m_rel = 0;
            m_addr = '0; m_wr = 1'b0; m_dw = '0; m_dr = '0;
         end else if (!m_open) begin
            m_ack = -1;
            best = -1; bestd = N;
            for (int i = 0; i < N; i++) begin
               if (rq[i]) begin
                  d = (i - m_ptr + N) % N;
                  if (d < bestd) begin bestd = d; best = i; end
               end
            end
            if (best >= 0) begin
               m_gid = best; m_addr = address[best*AW +: AW];
               m_wr = wr_ni[best]; m_dw = dataW[best*DW +: DW];
               m_open = 1'b1; m_acked = 1'b0;
            end
         end else if (!m_acked) begin
            m_ack = -1;
            if (srv_ack) begin
               m_acked = 1'b1; m_ack = m_gid; m_rel = 0;
               if (m_wr) m_dr = srv_dataR;
            end
         end else begin
            m_ack = -1;
            m_rel++;
            if (!rq[m_gid]) begin
               m_ptr = (m_gid + 1) % N; m_open = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_rel >= TMO) begin
               m_ptr = (m_gid + 1) % N; m_open = 1'b0; m_err = 1'b1;
            end
`endif
         end
         @(negedge clk);
         if (ack_epoch != seen_epoch) begin
            seen_epoch = ack_epoch;
            for (int i = 0; i < N; i++) ack_cnt[i] = 0;
         end
         for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
         if (srv_rq && !prev_srv_rq) begin
            g_id.push_back(int'(grant_id)); g_addr.push_back(int'(srv_address));
            g_wr.push_back(int'(srv_wr_ni)); g_dw.push_back(int'(srv_dataW));
         end
         prev_srv_rq = srv_rq;
         if (m_valid) begin
            exp_ack = (m_ack >= 0) ? (N'(1) << m_ack) : '0;
            chk("m_ack", ack, exp_ack);
            chk("m_srv_rq", srv_rq, m_open && !m_acked);
            chk("m_busy", busy, m_open);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_srv_address", srv_address, m_addr);
            chk("m_srv_wr_ni", srv_wr_ni, m_wr);
            chk("m_srv_dataW", srv_dataW, m_dw);
            chk("m_dataR", dataR, m_dr);
            chk("m_err_timeout", err_timeout, m_err);
         end
      end
   end

   // Server: acks srv_delay cycles after seeing srv_rq; can also inject a stray ack.
   initial begin : server
      int cnt;
      cnt = 0; srv_ack = 1'b0; srv_dataR = '0;
      forever begin
         @(posedge clk); #1;
         srv_ack = 1'b0;
         if (spur_seq != spur_done) begin
            spur_done = spur_seq; srv_ack = 1'b1; srv_dataR = 8'hEE; cnt = 0;
         end else if (srv_rq) begin
            cnt++;
            if (cnt >= srv_delay) begin srv_ack = 1'b1; srv_dataR = srv_rd_data; cnt = 0; end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (rr_cnt[i] > 0) begin
            rr_cnt[i]--;
            if (rr_cnt[i] == 0) rq[i] = 1'b1;
         end
         if (ack_seen[i] && !hold[i]) begin
            rq[i] = 1'b0;
            if (reraise_en) rr_cnt[i] = 2;
         end
      end
      ack_seen = ack;
   endtask

   task automatic wait_busy(input logic v, input int bound, input string nm);
      for (int k = 0; k < bound && busy !== v; k++) tick();
      chk(nm, busy, v);
   endtask

   task automatic wait_grants(input int n, input int bound, input string nm);
      for (int k = 0; k < bound && g_id.size() < n; k++) tick();
      chk(nm, (g_id.size() >= n), 1);
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 300 && (rq != 0 || busy || rr_pending()); k++) tick();
      chk(nm, {rq, busy}, 0);
   endtask

   initial begin : stim
      int n0;
      int exp_rr[5];
      exp_rr = '{0, 1, 2, 3, 0};
      reset = 1'b1; rq = '0; address = '0; wr_ni = '0; dataW = '0;
      srv_rd_data = '0; hold = '0; ack_seen = '0; reraise_en = 1'b0;
      for (int i = 0; i < N; i++) rr_cnt[i] = 0;
      tick(); tick();
      chk("rst_srv_rq", srv_rq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dataR", dataR, 0);
      chk("rst_grant_id", grant_id, 0);
      reset = 1'b0;
      tick();

      // single read from client 1
      n0 = g_id.size();
      address[1*AW +: AW] = 4'h3; wr_ni[1] = 1'b1; srv_rd_data = 8'hA5; srv_delay = 3; rq[1] = 1'b1;
      wait_busy(1'b1, 10, "rd_start");
      wait_busy(1'b0, 40, "rd_done");
      chk("rd_grant", gq(n0), 1);
      chk("rd_addr", aq(n0), 3);
      chk("rd_wr_ni", wq(n0), 1);
      chk("rd_dataR", dataR, 8'hA5);
      chk("rd_ack1", ack_cnt[1], 1);
      chk("rd_ack_other", ack_cnt[0] + ack_cnt[2] + ack_cnt[3], 0);

      // stray server ack while idle
      spur_seq++;
      tick(); tick(); tick();
      chk("spur_busy", busy, 0);
      chk("spur_dataR", dataR, 8'hA5);

      // write from client 0
      ack_epoch++;
      n0 = g_id.size();
      address[0 +: AW] = 4'h5; wr_ni[0] = 1'b0; dataW[0 +: DW] = 8'h04; srv_rd_data = 8'h77; rq[0] = 1'b1;
      wait_busy(1'b1, 10, "wr_start");
      wait_busy(1'b0, 40, "wr_done");
      chk("wr_grant", gq(n0), 0);
      chk("wr_wr_ni", wq(n0), 0);
      chk("wr_dataW", dq(n0), 8'h04);
      chk("wr_dataR_kept", dataR, 8'hA5);
      chk("wr_ack0", ack_cnt[0], 1);

      // address changes during SERVE must not reach the server
      n0 = g_id.size();
      address[3*AW +: AW] = 4'h3; wr_ni[3] = 1'b1; srv_delay = 6; srv_rd_data = 8'h5A; rq[3] = 1'b1;
      wait_busy(1'b1, 10, "fwd_start");
      tick();
      address[3*AW +: AW] = 4'h7;
      tick(); tick();
      chk("fwd_srv_rq", srv_rq, 1);
      chk("fwd_addr_hold", srv_address, 4'h3);
      wait_busy(1'b0, 40, "fwd_done");
      chk("fwd_grant", gq(n0), 3);
      chk("fwd_dataR", dataR, 8'h5A);

      // round robin with all clients requesting
      n0 = g_id.size();
      wr_ni = 4'hF; address = 16'h9ABC; srv_delay = 1; srv_rd_data = 8'h3C;
      reraise_en = 1'b1; rq = 4'hF;
      wait_grants(n0 + 5, 300, "rr_count");
      reraise_en = 1'b0;
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), gq(n0 + k), exp_rr[k]);
      drain("rr_drain");

      // reset in the middle of SERVE
      ack_epoch++;
      n0 = g_id.size();
      srv_delay = 100; rq = 4'b0100;
      wait_busy(1'b1, 10, "rmid_start");
      tick(); tick();
      reset = 1'b1; rq = 4'hF;
      tick();
      chk("rmid_srv_rq", srv_rq, 0);
      chk("rmid_busy", busy, 0);
      reset = 1'b0; srv_delay = 2;
      wait_grants(n0 + 2, 50, "rmid_regrant");
      chk("rmid_first", gq(n0), 2);
      chk("rmid_next", gq(n0 + 1), 0);
      chk("rmid_no_ack2", ack_cnt[2], 0);
      drain("rmid_drain");

      // client 2 never releases rq
      ack_epoch++;
      n0 = g_id.size();
      hold[2] = 1'b1; wr_ni[2] = 1'b0; dataW[2*DW +: DW] = 8'h22; srv_delay = 2; rq = 4'b0100;
      for (int k = 0; k < 30 && ack_cnt[2] == 0; k++) tick();
      chk("tmo_ack2", ack_cnt[2], 1);
      address[3*AW +: AW] = 4'hC; rq[3] = 1'b1;
`ifdef ARB_TIMEOUT_EN
      wait_grants(n0 + 2, 40, "tmo_regrant");
      chk("tmo_err", err_timeout, 1);
      chk("tmo_next", gq(n0 + 1), 3);
      hold[2] = 1'b0; rq[2] = 1'b0;
      drain("tmo_drain");
      chk("tmo_sticky", err_timeout, 1);
`else
      repeat (TMO + 4) tick();
      chk("tmo_busy", busy, 1);
      chk("tmo_err", err_timeout, 0);
      chk("tmo_srv_rq", srv_rq, 0);
      hold[2] = 1'b0; rq[2] = 1'b0;
      wait_grants(n0 + 2, 20, "tmo_regrant");
      chk("tmo_next", gq(n0 + 1), 3);
      drain("tmo_drain");
`endif

      reset = 1'b1;
      tick();
      chk("end_rst_err", err_timeout, 0);
      chk("end_rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter between NUM_CLIENTS bus clients and one shared server. Each client uses an rq/ack handshake: it raises rq and drives address/wr_ni/dataW, then drops rq the cycle after it sees a one-cycle ack. The arbiter grants one client, forwards its transfer to the server over the same rq/ack protocol, returns read data, and rotates priority.

Parameters:
NUM_CLIENTS, 4, number of client ports (>=2)
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 4, address bus width
RELEASE_TIMEOUT, 16, cycles allowed in RELEASE for rq to drop (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active 1
rq  input  NUM_CLIENTS  per-client request, bit i = client i
ack  output  NUM_CLIENTS  per-client acknowledge, one-cycle pulse
address  input  NUM_CLIENTS*ADDR_WIDTH  client addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wr_ni  input  NUM_CLIENTS  per-client op select: 1 = read, 0 = write
dataW  input  NUM_CLIENTS*DATA_WIDTH  client write data, client i at [i*DATA_WIDTH +: DATA_WIDTH]
dataR  output  DATA_WIDTH  read data broadcast to all clients
srv_rq  output  1  request to server
srv_ack  input  1  server acknowledge, one-cycle pulse
srv_address  output  ADDR_WIDTH  forwarded address
srv_wr_ni  output  1  forwarded op select
srv_dataW  output  DATA_WIDTH  forwarded write data
srv_dataR  input  DATA_WIDTH  server read data, valid in the srv_ack cycle
grant_id  output  clog2(NUM_CLIENTS)  index of the current or last granted client
busy  output  1  1 when state != IDLE
err_timeout  output  1  sticky release-timeout flag

Behaviour:
- All outputs are registered. The synchronous reset takes effect on the clk edge where reset=1.
- Reset values: ack=0, dataR=0, srv_rq=0, srv_address=0, srv_wr_ni=0, srv_dataW=0, grant_id=0, busy=0, err_timeout=0. Internal round-robin pointer ptr=0. State=IDLE.
- FSM states: IDLE, SERVE, RELEASE.
- IDLE:
  - If rq==0, stay in IDLE.
  - Otherwise the winner is the first set rq bit at index ptr, ptr+1, ..., wrapping past NUM_CLIENTS-1 to 0.
  - On the same edge: grant_id<=winner. Latch the winner's address, wr_ni and dataW into srv_address, srv_wr_ni and srv_dataW. srv_rq<=1. Go to SERVE.
  - Latency: rq sampled high at edge t gives srv_rq=1 after edge t.
- SERVE:
  - Hold srv_rq and the latched srv_* values; later changes on the client inputs are ignored.
  - On srv_ack=1: srv_rq<=0, ack[grant_id]<=1 (all other ack bits stay 0), go to RELEASE.
  - In that same cycle, if srv_wr_ni=1, dataR<=srv_dataR. On a write, dataR is unchanged.
- RELEASE:
  - ack<=0, so ack is exactly one cycle wide.
  - Wait for rq[grant_id]==0. When seen: ptr<=(grant_id+1) mod NUM_CLIENTS, go to IDLE.
  - A client that drops rq on the edge after ack causes a 2-cycle RELEASE.
- rq from other clients during SERVE/RELEASE is ignored; those clients are arbitrated in IDLE afterwards.
- Fairness: with all rq held high, grants go 0,1,2,3,0,...
- The next grant can be issued no earlier than the edge after the return to IDLE, so there is at least one IDLE cycle between transactions.
- srv_ack while in IDLE or RELEASE is ignored.
- dataR holds its value until the next completed read.
- Reset mid-transaction aborts it: the FSM returns to IDLE, ptr=0, and no ack is issued.

Optional Feature:
ARB_TIMEOUT_EN.
- Defined: a counter runs in RELEASE. If rq[grant_id] is still 1 after RELEASE_TIMEOUT cycles in RELEASE, the arbiter forces ptr<=(grant_id+1) mod NUM_CLIENTS, goes to IDLE, and sets err_timeout<=1. err_timeout is sticky and is cleared only by reset.
- Not defined: RELEASE waits indefinitely, err_timeout is tied 0, and no counter is built. The port list is identical in both builds.

Test Plan:
- Single read: reset, then rq=4'b0010, wr_ni[1]=1, client-1 address=4'h3; server acks 3 cycles after srv_rq with srv_dataR=8'hA5 -> srv_address=3, srv_wr_ni=1, one ack pulse on ack[1] only, dataR=8'hA5, grant_id=1, busy returns to 0.
- Write: client 0 wr_ni=0, dataW=8'h04 -> srv_wr_ni=0, srv_dataW=8'h04, ack[0] pulse, dataR unchanged from its previous value.
- Round robin: rq=4'b1111 held, with each client re-raising rq 2 cycles after its ack -> grant order 0,1,2,3,0; no client is granted twice in a row while others are requesting.
- Stable forwarding: client changes address from 3 to 7 during SERVE -> srv_address stays 3 until srv_ack.
- Reset mid-SERVE: assert reset for 1 cycle before srv_ack -> ack never pulses, srv_rq=0, busy=0, and the next grant with rq=4'b1111 goes to client 0.
- ARB_TIMEOUT_EN: client 2 holds rq high after its ack -> after RELEASE_TIMEOUT=16 cycles err_timeout=1, the next grant goes to client 3; without the macro busy stays 1 and err_timeout stays 0.
